// File: rtl/trng_ctrl.sv
// TRNG sequencing controller: source enable, startup health window with retries, word packing, sticky fault.
// Optional statistics counters (words_out, dropped_bits) are built when TRNG_CTRL_STATS_EN is defined.
module trng_ctrl #(
  parameter int STARTUP_BITS = 1024,
  parameter int WORD_W       = 32,
  parameter int MAX_RETRIES  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              fault_ack,
  input  logic              bit_in,
  input  logic              bit_strobe,
  input  logic              health_fail,
  output logic              health_clear,
  output logic              src_en,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        state,
  output logic [3:0]        retry_cnt,
  output logic              fault,
  output logic [15:0]       words_out,
  output logic [15:0]       dropped_bits
);

  localparam int SCW = $clog2(STARTUP_BITS + 1);
  localparam int BCW = $clog2(WORD_W + 1);
  localparam logic [SCW-1:0] SC_LAST  = SCW'(STARTUP_BITS - 1);
  localparam logic [BCW-1:0] BC_LAST  = BCW'(WORD_W - 1);
  localparam logic [BCW-1:0] BC_FULL  = BCW'(WORD_W);
  localparam logic [3:0]     MAX_R    = 4'(MAX_RETRIES);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STARTUP = 2'd1,
    S_RUN     = 2'd2,
    S_FAULT   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              clear_q, clear_d;
  logic              src_en_q, src_en_d;
  logic              fault_q, fault_d;
  logic [3:0]        retry_q, retry_d;
  logic [SCW-1:0]    scnt_q, scnt_d;
  logic [BCW-1:0]    bcnt_q, bcnt_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              hold_valid_q, hold_valid_d;

  logic exp_valid;
  logic xfer;
  logic ack;
  logic drop_inc;

  // A word is never offered while the health block is flagging a failure.
  assign exp_valid    = hold_valid_q & ~health_fail;
  assign xfer         = exp_valid & out_ready;
  assign ack          = (state_q == S_FAULT) & fault_ack;
  assign health_clear = clear_q | ack;

  assign out_valid = exp_valid;
  assign out_data  = hold_q;
  assign state     = state_q;
  assign src_en    = src_en_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;

  always_comb begin
    state_d      = state_q;
    clear_d      = 1'b0;
    retry_d      = retry_q;
    scnt_d       = scnt_q;
    bcnt_d       = bcnt_q;
    sreg_d       = sreg_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    drop_inc     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_STARTUP;
          clear_d = 1'b1;
          retry_d = 4'd0;
          scnt_d  = '0;
        end
      end
      S_STARTUP: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (clear_q) begin
          // Health block is being cleared this cycle; its outputs and strobes are not trusted.
          scnt_d = '0;
        end else if (health_fail) begin
          if (retry_q < MAX_R) begin
            retry_d = retry_q + 4'd1;
            clear_d = 1'b1;
            scnt_d  = '0;
          end else begin
            state_d = S_FAULT;
          end
        end else if (bit_strobe) begin
          if (scnt_q == SC_LAST) begin
            state_d = S_RUN;
            bcnt_d  = '0;
            sreg_d  = '0;
          end else begin
            scnt_d = scnt_q + SCW'(1);
          end
        end
      end
      S_RUN: begin
        if (health_fail || !en) begin
          state_d      = health_fail ? S_FAULT : S_IDLE;
          hold_d       = '0;
          hold_valid_d = 1'b0;
          sreg_d       = '0;
          bcnt_d       = '0;
        end else begin
          if (xfer) hold_valid_d = 1'b0;
          if (bcnt_q == BC_FULL) begin
            // Completed word parked in the shift register waiting for the holding slot.
            if (!hold_valid_q || xfer) begin
              hold_d       = sreg_q;
              hold_valid_d = 1'b1;
              sreg_d       = '0;
              bcnt_d       = '0;
              if (bit_strobe) begin
                sreg_d = WORD_W'(bit_in);
                bcnt_d = BCW'(1);
              end
            end else if (bit_strobe) begin
              drop_inc = 1'b1;
            end
          end else if (bit_strobe) begin
            sreg_d = sreg_q | (WORD_W'(bit_in) << bcnt_q);
            if (bcnt_q == BC_LAST) begin
              if (!hold_valid_q || xfer) begin
                hold_d       = sreg_d;
                hold_valid_d = 1'b1;
                sreg_d       = '0;
                bcnt_d       = '0;
              end else begin
                bcnt_d = BC_FULL;
              end
            end else begin
              bcnt_d = bcnt_q + BCW'(1);
            end
          end
        end
      end
      S_FAULT: begin
        if (fault_ack) begin
          state_d = S_IDLE;
          retry_d = 4'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    src_en_d = (state_d == S_STARTUP) || (state_d == S_RUN);
    fault_d  = (state_d == S_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      clear_q      <= 1'b0;
      src_en_q     <= 1'b0;
      fault_q      <= 1'b0;
      retry_q      <= 4'd0;
      scnt_q       <= '0;
      bcnt_q       <= '0;
      sreg_q       <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clear_q      <= clear_d;
      src_en_q     <= src_en_d;
      fault_q      <= fault_d;
      retry_q      <= retry_d;
      scnt_q       <= scnt_d;
      bcnt_q       <= bcnt_d;
      sreg_q       <= sreg_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end

`ifdef TRNG_CTRL_STATS_EN
  logic [15:0] words_q, words_d;
  logic [15:0] drop_q, drop_d;

  always_comb begin
    words_d = words_q;
    drop_d  = drop_q;
    if (ack) begin
      words_d = 16'd0;
      drop_d  = 16'd0;
    end else begin
      if (xfer && (words_q != 16'hFFFF)) words_d = words_q + 16'd1;
      if (drop_inc && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_q <= 16'd0;
      drop_q  <= 16'd0;
    end else begin
      words_q <= words_d;
      drop_q  <= drop_d;
    end
  end

  assign words_out    = words_q;
  assign dropped_bits = drop_q;
`else
  logic unused_drop_inc;
  assign unused_drop_inc = drop_inc;
  assign words_out       = 16'd0;
  assign dropped_bits    = 16'd0;
`endif

endmodule

// File: tb/tb_trng_ctrl.sv
// Directed-plus-random bench for trng_ctrl, every cycle compared against a queue-based reference model.
module tb_trng_ctrl;

  localparam int SB = 1024;
  localparam int WW = 32;
  localparam int MR = 3;
`ifdef TRNG_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          fault_ack = 1'b0;
  logic          bit_in = 1'b0;
  logic          bit_strobe = 1'b0;
  logic          health_fail = 1'b0;
  logic          out_ready = 1'b0;
  logic          health_clear;
  logic          src_en;
  logic [WW-1:0] out_data;
  logic          out_valid;
  logic [1:0]    state;
  logic [3:0]    retry_cnt;
  logic          fault;
  logic [15:0]   words_out;
  logic [15:0]   dropped_bits;

  trng_ctrl #(.STARTUP_BITS(SB), .WORD_W(WW), .MAX_RETRIES(MR)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fault_ack(fault_ack),
    .bit_in(bit_in), .bit_strobe(bit_strobe), .health_fail(health_fail),
    .health_clear(health_clear), .src_en(src_en), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .state(state),
    .retry_cnt(retry_cnt), .fault(fault), .words_out(words_out),
    .dropped_bits(dropped_bits)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int hclr_seen = 0;
  logic last_ov, last_hc;

  // Reference model: 0=IDLE 1=STARTUP 2=RUN 3=FAULT, partial word kept as a bit queue.
  int          m_state, m_retry, m_cnt, m_words, m_drop;
  bit          m_clr, m_hv;
  logic [WW-1:0] m_hd;
  bit          m_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_retry = 0; m_cnt = 0; m_words = 0; m_drop = 0;
    m_clr = 0; m_hv = 0; m_hd = '0; m_q.delete();
  endtask

  task automatic load_hold();
    for (int i = 0; i < WW; i++) m_hd[i] = m_q[i];
    m_hv = 1;
    m_q.delete();
  endtask

  task automatic discard();
    m_hv = 0; m_hd = '0; m_q.delete();
  endtask

  task automatic model_next(input logic e, fa, bi, bs, hf, xf);
    if (xf && m_words < 65535) m_words++;
    case (m_state)
      0: if (e) begin m_state = 1; m_clr = 1; m_retry = 0; m_cnt = 0; end
      1: begin
        if (!e) begin m_state = 0; m_clr = 0; end
        else if (m_clr) begin m_clr = 0; m_cnt = 0; end
        else if (hf) begin
          if (m_retry < MR) begin m_retry++; m_clr = 1; m_cnt = 0; end
          else m_state = 3;
        end else if (bs) begin
          m_cnt++;
          if (m_cnt == SB) begin m_state = 2; m_q.delete(); end
        end
      end
      2: begin
        if (hf) begin m_state = 3; discard(); end
        else if (!e) begin m_state = 0; discard(); end
        else begin
          if (xf) m_hv = 0;
          if (m_q.size() == WW && !m_hv) load_hold();
          if (bs) begin
            if (m_q.size() == WW) begin
              if (m_drop < 65535) m_drop++;
            end else begin
              m_q.push_back(bi);
              if (m_q.size() == WW && !m_hv) load_hold();
            end
          end
        end
      end
      default: if (fa) begin m_state = 0; m_retry = 0; m_words = 0; m_drop = 0; end
    endcase
  endtask

  // One clock cycle: drive, check combinational outputs, advance model, check registered outputs.
  task automatic cyc(input logic e, fa, bi, bs, hf, rdy);
    logic exp_hc, exp_ov, xf;
    en = e; fault_ack = fa; bit_in = bi; bit_strobe = bs; health_fail = hf; out_ready = rdy;
    #1;
    exp_hc = m_clr || (m_state == 3 && fa);
    exp_ov = m_hv && !hf;
    xf = exp_ov && rdy;
    last_ov = out_valid;
    last_hc = health_clear;
    chk("health_clear", health_clear, exp_hc);
    chk("out_valid", out_valid, exp_ov);
    if (health_clear) hclr_seen++;
    model_next(e, fa, bi, bs, hf, xf);
    @(posedge clk);
    #1;
    chk("state", state, m_state);
    chk("retry_cnt", retry_cnt, m_retry);
    chk("src_en", src_en, (m_state == 1 || m_state == 2));
    chk("fault", fault, (m_state == 3));
    chk("out_data", out_data, m_hd);
    chk("words_out", words_out, STATS ? m_words : 0);
    chk("dropped_bits", dropped_bits, STATS ? m_drop : 0);
  endtask

  // mode 0: alternating bits, 1: random bits, 2: first bit 1 then zeros. Random idle gaps between strobes.
  task automatic run_strobes(input int n, input int mode, input logic rdy);
    logic b;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) cyc(1, 0, 0, 0, 0, rdy);
      case (mode)
        0: b = i[0];
        2: b = (i == 0);
        default: b = $urandom_range(0, 1) == 1;
      endcase
      cyc(1, 0, b, 1, 0, rdy);
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_src_en", src_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_health_clear", health_clear, 0);
    chk("rst_fault", fault, 0);
    chk("rst_retry", retry_cnt, 0);
    chk("rst_words", words_out, 0);
    chk("rst_dropped", dropped_bits, 0);
    rst_n = 1'b1;

    // Startup pass then first word.
    hclr_seen = 0;
    cyc(1, 0, 0, 0, 0, 0);
    chk("su_state_startup", state, 1);
    cyc(1, 0, 0, 1, 0, 0);
    run_strobes(SB - 1, 0, 0);
    chk("su_not_yet_run", state, 1);
    run_strobes(1, 0, 0);
    chk("su_state_run", state, 2);
    chk("su_clear_pulses", hclr_seen, 1);
    run_strobes(WW, 2, 0);
    chk("word0_data", out_data, 32'h0000_0001);
    chk("word0_valid", out_valid, 1);
    cyc(1, 0, 0, 0, 0, 1);
    chk("word0_words", words_out, STATS ? 1 : 0);

    // Backpressure: one word held, one parked, six bits dropped.
    run_strobes(70, 1, 0);
    chk("bp_dropped", dropped_bits, STATS ? 6 : 0);
    chk("bp_valid", out_valid, 1);
    cyc(1, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 1);
    chk("bp_words", words_out, STATS ? 3 : 0);
    chk("bp_drained", out_valid, 0);

    // Run-time fail with a held word.
    run_strobes(WW, 1, 0);
    chk("rf_valid_before", out_valid, 1);
    cyc(1, 0, 0, 0, 1, 1);
    chk("rf_valid_gated", last_ov, 0);
    chk("rf_state_fault", state, 3);
    chk("rf_fault", fault, 1);
    chk("rf_src_en", src_en, 0);
    chk("rf_no_xfer", words_out, STATS ? 3 : 0);
    cyc(1, 0, 1, 1, 0, 1);
    chk("rf_ignore_en", state, 3);
    cyc(1, 1, 0, 0, 0, 0);
    chk("ack_clear_pulse", last_hc, 1);
    chk("ack_state_idle", state, 0);
    chk("ack_words_clr", words_out, 0);

    // Startup retry at strobe 100.
    hclr_seen = 0;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    run_strobes(100, 0, 0);
    cyc(1, 0, 0, 0, 1, 0);
    chk("retry_cnt_1", retry_cnt, 1);
    chk("retry_state", state, 1);
    cyc(1, 0, 0, 0, 0, 0);
    run_strobes(SB - 1, 1, 0);
    chk("retry_not_yet_run", state, 1);
    run_strobes(1, 1, 0);
    chk("retry_state_run", state, 2);
    chk("retry_clear_pulses", hclr_seen, 2);
    chk("retry_cnt_kept", retry_cnt, 1);

    // Retry exhaustion.
    cyc(0, 0, 0, 0, 0, 0);
    chk("off_retry_kept", retry_cnt, 1);
    cyc(1, 0, 0, 0, 0, 0);
    chk("en_rise_retry_zero", retry_cnt, 0);
    for (int a = 0; a <= MR; a++) begin
      cyc(1, 0, 0, 0, 0, 0);
      run_strobes($urandom_range(1, 50), 1, 0);
      cyc(1, 0, 0, 0, 1, 0);
      if (a < MR) chk("exh_retry", retry_cnt, a + 1);
    end
    chk("exh_state", state, 3);
    chk("exh_fault", fault, 1);
    chk("exh_src_en", src_en, 0);
    chk("exh_retry_max", retry_cnt, MR);
    cyc(0, 1, 0, 0, 0, 0);
    chk("exh_ack_idle", state, 0);
    chk("exh_ack_retry", retry_cnt, 0);

    // en dropped at strobe 500, then a full window again.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    run_strobes(500, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("off_state_idle", state, 0);
    chk("off_src_en", src_en, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("reen_retry", retry_cnt, 0);
    cyc(1, 0, 0, 0, 0, 0);
    run_strobes(SB - 1, 1, 0);
    chk("reen_not_yet_run", state, 1);
    run_strobes(1, 1, 0);
    chk("reen_state_run", state, 2);

    // Asynchronous reset while a word is offered.
    run_strobes(WW, 1, 0);
    chk("ar_valid_before", out_valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_valid_drop", out_valid, 0);
    chk("ar_state", state, 0);
    chk("ar_data", out_data, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Random traffic against the model.
    for (int c = 0; c < 6000; c++) begin
      logic e, fa, hf;
      e  = ($urandom_range(0, 2999) != 0);
      hf = ($urandom_range(0, 2499) == 0);
      fa = (m_state == 3) && ($urandom_range(0, 3) == 0);
      cyc(e, fa, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, hf, $urandom_range(0, 2) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
